// File: rtl/pipeline_pkg.sv
// pipeline_pkg
// Shared definitions for the 5-stage RV64 pipeline.
//   if_state_e       : fetch-stage control states
//   RV_NOP           : canonical RV NOP (addi x0, x0, 0), used for bubbles
//   RESET_PC_DEFAULT : default first fetch address after reset
//   word_align()     : clears the two low address bits of a PC
package pipeline_pkg;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } if_state_e;

   localparam logic [31:0] RV_NOP           = 32'h0000_0013;
   localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

   // Instructions are 32-bit aligned; redirect targets are forced onto that grid.
   function automatic logic [63:0] word_align(input logic [63:0] addr);
      return addr & 64'hFFFF_FFFF_FFFF_FFFC;
   endfunction

endpackage

// File: rtl/pipeline_if_stage1.sv
// pipeline_if_stage1
// Instruction fetch stage. Holds the fetch PC, issues one outstanding request
// at a time to instruction memory (req/gnt/rvalid) and hands each fetched word
// with its PC to decode through registered outputs.
// Ports:
//   clk, reset (async, active-low)
//   stall                        : decode is holding; output registers freeze
//   redirect_valid, redirect_pc  : branch/jump/flush target (low 2 bits ignored)
//   imem_req, imem_addr          : fetch request and address (current PC)
//   imem_gnt, imem_rvalid,
//   imem_rdata                   : memory accept, data valid, instruction word
//   instruction_IF, pc_IFR,
//   valid_IF                     : registered instruction, its PC, valid flag
module pipeline_if_stage1
   import pipeline_pkg::*;
#(
   parameter logic [63:0] RESET_PC = pipeline_pkg::RESET_PC_DEFAULT,
   parameter logic [31:0] NOP_INST = pipeline_pkg::RV_NOP
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instruction_IF,
   output logic [63:0] pc_IFR,
   output logic        valid_IF
);

   if_state_e   state_r;
   if_state_e   state_nxt_s;
   logic [63:0] pc_r;
   logic [63:0] pc_nxt_s;
   logic        drop_r;
   logic        drop_nxt_s;
   logic [31:0] hold_inst_r;
   logic [31:0] hold_inst_nxt_s;
   logic [63:0] hold_pc_r;
   logic [63:0] hold_pc_nxt_s;

   logic        deliver_s;
   logic [31:0] deliver_inst_s;
   logic [63:0] deliver_pc_s;
   logic [63:0] target_s;
   logic [31:0] inst_nxt_s;
   logic [63:0] pc_out_nxt_s;
   logic        valid_nxt_s;

   assign imem_addr = pc_r;

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= S_REQ;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Fetch PC, wrong-path drop flag, one-entry hold buffer and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_r           <= RESET_PC;
         drop_r         <= 1'b0;
         hold_inst_r    <= NOP_INST;
         hold_pc_r      <= 64'd0;
         instruction_IF <= NOP_INST;
         pc_IFR         <= 64'd0;
         valid_IF       <= 1'b0;
      end else begin
         pc_r           <= pc_nxt_s;
         drop_r         <= drop_nxt_s;
         hold_inst_r    <= hold_inst_nxt_s;
         hold_pc_r      <= hold_pc_nxt_s;
         instruction_IF <= inst_nxt_s;
         pc_IFR         <= pc_out_nxt_s;
         valid_IF       <= valid_nxt_s;
      end
   end

   // Next-state, request and output-register selection. Redirect wins over
   // everything else in every state.
   always_comb begin
      state_nxt_s     = state_r;
      pc_nxt_s        = pc_r;
      drop_nxt_s      = drop_r;
      hold_inst_nxt_s = hold_inst_r;
      hold_pc_nxt_s   = hold_pc_r;
      imem_req        = 1'b0;
      deliver_s       = 1'b0;
      deliver_inst_s  = NOP_INST;
      deliver_pc_s    = pc_r;
      target_s        = word_align(redirect_pc);

      case (state_r)
         S_REQ: begin
            // No request in a redirect cycle: the PC is about to change.
            imem_req = !redirect_valid;
            if (redirect_valid) begin
               pc_nxt_s = target_s;
            end else if (imem_gnt) begin
               state_nxt_s = S_WAIT;
            end else begin
               state_nxt_s = S_REQ;
            end
         end
         S_WAIT: begin
            if (redirect_valid) begin
               pc_nxt_s = target_s;
               if (imem_rvalid) begin
                  drop_nxt_s  = 1'b0;
                  state_nxt_s = S_REQ;
               end else begin
                  // Response still in flight belongs to the old path.
                  drop_nxt_s  = 1'b1;
               end
            end else if (imem_rvalid) begin
               if (drop_r) begin
                  drop_nxt_s  = 1'b0;
                  state_nxt_s = S_REQ;
               end else if (!stall) begin
                  deliver_s      = 1'b1;
                  deliver_inst_s = imem_rdata;
                  deliver_pc_s   = pc_r;
                  pc_nxt_s       = pc_r + 64'd4;
                  state_nxt_s    = S_REQ;
               end else begin
                  hold_inst_nxt_s = imem_rdata;
                  hold_pc_nxt_s   = pc_r;
                  pc_nxt_s        = pc_r + 64'd4;
                  state_nxt_s     = S_HOLD;
               end
            end else begin
               state_nxt_s = S_WAIT;
            end
         end
         S_HOLD: begin
            if (redirect_valid) begin
               pc_nxt_s    = target_s;
               state_nxt_s = S_REQ;
            end else if (!stall) begin
               deliver_s      = 1'b1;
               deliver_inst_s = hold_inst_r;
               deliver_pc_s   = hold_pc_r;
               state_nxt_s    = S_REQ;
            end else begin
               state_nxt_s = S_HOLD;
            end
         end
         default: begin
            state_nxt_s = S_REQ;
         end
      endcase

      // Bubbles keep the last PC on pc_IFR; only the word and valid change.
      if (redirect_valid) begin
         inst_nxt_s   = NOP_INST;
         pc_out_nxt_s = pc_IFR;
         valid_nxt_s  = 1'b0;
      end else if (stall) begin
         inst_nxt_s   = instruction_IF;
         pc_out_nxt_s = pc_IFR;
         valid_nxt_s  = valid_IF;
      end else if (deliver_s) begin
         inst_nxt_s   = deliver_inst_s;
         pc_out_nxt_s = deliver_pc_s;
         valid_nxt_s  = 1'b1;
      end else begin
         inst_nxt_s   = NOP_INST;
         pc_out_nxt_s = pc_IFR;
         valid_nxt_s  = 1'b0;
      end
   end

endmodule

// File: tb/tb_pipeline_if_stage1.sv
// tb_pipeline_if_stage1
// Self-checking bench for pipeline_if_stage1: a behavioural memory drives the
// handshake, a transaction-level model (queues of in-flight fetches and held
// words) predicts every output each cycle, and directed sequences plus a
// redirect vector table cover the multi-cycle corner cases.
module tb_pipeline_if_stage1;

   localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = 64'd0;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic [31:0] instruction_IF;
   logic [63:0] pc_IFR;
   logic        valid_IF;

   always #5 clk = ~clk;

   pipeline_if_stage1 dut (
      .clk(clk), .reset(reset), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instruction_IF(instruction_IF), .pc_IFR(pc_IFR), .valid_IF(valid_IF)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state
   typedef struct { logic [63:0] addr; bit stale; } fetch_t;
   typedef struct { logic [31:0] inst; logic [63:0] pc; } word_t;
   fetch_t      inflight[$];
   word_t       held[$];
   logic [63:0] m_pc;
   logic [31:0] m_inst;
   logic [63:0] m_pcout;
   bit          m_valid;

   // Memory model state
   bit          mem_busy = 1'b0;
   int          mem_cnt = 0;
   logic [63:0] mem_addr = 64'd0;
   int          gnt_pct = 100;
   int          lat_min = 1;
   int          lat_max = 1;

   bit          last_req;
   logic [63:0] last_addr;

   typedef struct { logic [63:0] rpc; logic [63:0] exp_addr; logic [63:0] exp_next; } redir_vec_t;
   redir_vec_t vecs[4];

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return a[31:0] ^ a[63:32] ^ 32'hC0DE_1001;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model one clock edge from the inputs seen during the cycle.
   task automatic model_edge(input bit st, input bit rdr, input logic [63:0] rpc,
                             input bit granted, input bit rv);
      fetch_t f;
      word_t  w;
      bit     deliver;
      deliver = 1'b0;
      w = '{inst: NOP, pc: 64'd0};
      if (rdr) begin
         if (inflight.size() > 0) begin
            if (rv) f = inflight.pop_front();
            else    inflight[0].stale = 1'b1;
         end
         held.delete();
         m_pc    = rpc & 64'hFFFF_FFFF_FFFF_FFFC;
         m_inst  = NOP;
         m_valid = 1'b0;
      end else begin
         if (rv && inflight.size() > 0) begin
            f = inflight.pop_front();
            if (!f.stale) begin
               w = '{inst: mem_word(f.addr), pc: f.addr};
               if (st) held.push_back(w);
               else    deliver = 1'b1;
               m_pc = f.addr + 64'd4;
            end
         end else if (held.size() > 0 && !st) begin
            w = held.pop_front();
            deliver = 1'b1;
         end
         if (granted) inflight.push_back('{addr: m_pc, stale: 1'b0});
         if (!st) begin
            if (deliver) begin
               m_inst = w.inst; m_pcout = w.pc; m_valid = 1'b1;
            end else begin
               m_inst = NOP; m_valid = 1'b0;
            end
         end
      end
   endtask

   // One clock cycle, entered and left just after a falling edge.
   task automatic cycle();
      bit          rv, exp_req, g;
      logic [63:0] a;
      rv = mem_busy && (mem_cnt == 0);
      imem_rvalid = rv;
      imem_rdata  = rv ? mem_word(mem_addr) : $urandom();
      #1;
      exp_req = !redirect_valid && inflight.size() == 0 && held.size() == 0;
      chk("imem_req", {63'd0, imem_req}, {63'd0, exp_req});
      if (exp_req) chk("imem_addr", imem_addr, m_pc);
      last_req  = imem_req;
      last_addr = imem_addr;
      a = imem_addr;
      g = imem_req && !mem_busy && ($urandom_range(0, 99) < gnt_pct);
      imem_gnt = g;
      @(posedge clk);
      model_edge(stall, redirect_valid, redirect_pc, g && exp_req, rv);
      if (rv) mem_busy = 1'b0;
      else if (mem_busy) mem_cnt--;
      if (g) begin
         mem_busy = 1'b1;
         mem_addr = a;
         mem_cnt  = $urandom_range(lat_min, lat_max) - 1;
      end
      @(negedge clk);
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      chk("out_valid", {63'd0, valid_IF}, {63'd0, m_valid});
      chk("out_inst", {32'd0, instruction_IF}, {32'd0, m_inst});
      chk("out_pc", pc_IFR, m_pcout);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      stall = 1'b0;
      redirect_valid = 1'b0;
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
      inflight.delete();
      held.delete();
      m_pc = RPC; m_inst = NOP; m_pcout = 64'd0; m_valid = 1'b0;
      mem_busy = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_inst", {32'd0, instruction_IF}, {32'd0, NOP});
      chk("rst_pc_IFR", pc_IFR, 64'd0);
      chk("rst_valid", {63'd0, valid_IF}, 64'd0);
      chk("rst_addr", imem_addr, RPC);
      reset = 1'b1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      stall = 1'b0;
      redirect_valid = 1'b0;
      while ((inflight.size() != 0 || held.size() != 0 || mem_busy) && n < 20) begin
         cycle();
         n++;
      end
      checks++;
      if (n >= 20) begin
         errors++;
         $display("FAIL wait_idle: got %0d cycles expected < 20", n);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{rpc: 64'h0000_0000_8000_0203, exp_addr: 64'h0000_0000_8000_0200, exp_next: 64'h0000_0000_8000_0204};
      vecs[1] = '{rpc: 64'hFFFF_FFFF_FFFF_FFFC, exp_addr: 64'hFFFF_FFFF_FFFF_FFFC, exp_next: 64'h0000_0000_0000_0000};
      vecs[2] = '{rpc: 64'h0000_0000_0000_0001, exp_addr: 64'h0000_0000_0000_0000, exp_next: 64'h0000_0000_0000_0004};
      vecs[3] = '{rpc: 64'h1234_5678_9ABC_DEF2, exp_addr: 64'h1234_5678_9ABC_DEF0, exp_next: 64'h1234_5678_9ABC_DEF4};

      // Startup with zero-wait memory: valid pulses in cycles 3 and 5.
      do_reset();
      gnt_pct = 100; lat_min = 1; lat_max = 1;
      for (int n = 1; n <= 5; n++) begin
         cycle();
         chk("startup_valid", {63'd0, valid_IF}, {63'd0, (n == 2 || n == 4)});
         if (n == 2) chk("startup_pc0", pc_IFR, 64'h0000_0000_8000_0000);
         if (n == 4) chk("startup_pc1", pc_IFR, 64'h0000_0000_8000_0004);
      end

      // Stall across the response: word parked, released one cycle after stall drops.
      begin
         logic [63:0] a;
         wait_idle();
         lat_min = 2; lat_max = 2;
         a = m_pc;
         cycle();
         stall = 1'b1;
         repeat (4) cycle();
         chk("stall_held_valid", {63'd0, valid_IF}, 64'd0);
         stall = 1'b0;
         cycle();
         chk("stall_rel_valid", {63'd0, valid_IF}, 64'd1);
         chk("stall_rel_pc", pc_IFR, a);
         chk("stall_rel_inst", {32'd0, instruction_IF}, {32'd0, mem_word(a)});
      end

      // Redirect while waiting; the late response must be dropped.
      wait_idle();
      lat_min = 4; lat_max = 4;
      cycle();
      redirect_valid = 1'b1; redirect_pc = 64'h0000_0000_8000_0100;
      cycle();
      redirect_valid = 1'b0;
      for (int n = 0; n < 10 && inflight.size() != 0; n++) begin
         cycle();
         chk("stale_never_valid", {63'd0, valid_IF}, 64'd0);
      end
      lat_min = 1; lat_max = 1;
      cycle();
      chk("redir_wait_req", {63'd0, last_req}, 64'd1);
      chk("redir_wait_addr", last_addr, 64'h0000_0000_8000_0100);

      // Redirect coinciding with rvalid under stall.
      wait_idle();
      cycle();
      stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h0000_0000_8000_0300;
      cycle();
      chk("redir_rv_inst", {32'd0, instruction_IF}, {32'd0, NOP});
      chk("redir_rv_valid", {63'd0, valid_IF}, 64'd0);
      stall = 1'b0; redirect_valid = 1'b0;
      cycle();
      chk("redir_rv_addr", last_addr, 64'h0000_0000_8000_0300);

      // Redirect vector table: alignment and wrap.
      for (int i = 0; i < 4; i++) begin
         wait_idle();
         redirect_valid = 1'b1; redirect_pc = vecs[i].rpc;
         cycle();
         chk("tbl_bubble", {63'd0, valid_IF}, 64'd0);
         redirect_valid = 1'b0;
         cycle();
         chk("tbl_addr", last_addr, vecs[i].exp_addr);
         cycle();
         chk("tbl_out_pc", pc_IFR, vecs[i].exp_addr);
         chk("tbl_out_valid", {63'd0, valid_IF}, 64'd1);
         cycle();
         chk("tbl_next", last_addr, vecs[i].exp_next);
      end

      // Asynchronous reset in the middle of a wait.
      wait_idle();
      lat_min = 3; lat_max = 3;
      cycle();
      cycle();
      #2;
      reset = 1'b0;
      #1;
      chk("async_rst_valid", {63'd0, valid_IF}, 64'd0);
      chk("async_rst_inst", {32'd0, instruction_IF}, {32'd0, NOP});
      chk("async_rst_pc", pc_IFR, 64'd0);
      chk("async_rst_addr", imem_addr, RPC);
      chk("async_rst_req", {63'd0, imem_req}, 64'd1);
      @(negedge clk);
      do_reset();
      lat_min = 1; lat_max = 1;
      cycle();
      chk("post_rst_addr", last_addr, RPC);

      // Randomized traffic against the model.
      gnt_pct = 70; lat_min = 1; lat_max = 3;
      for (int n = 0; n < 400; n++) begin
         stall = ($urandom_range(0, 99) < 30);
         redirect_valid = ($urandom_range(0, 99) < 8);
         if ($urandom_range(0, 3) == 0)
            redirect_pc = {32'hFFFF_FFFF, 32'hFFFF_FFF0 | 32'($urandom_range(0, 15))};
         else
            redirect_pc = {32'h0000_0000, $urandom()};
         cycle();
      end
      stall = 1'b0;
      redirect_valid = 1'b0;
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_if_stage1.md
# pipeline_if_stage1

Instruction fetch stage for the 5-stage RV64 pipeline. Holds the architectural fetch PC and issues single-outstanding requests to instruction memory over a req/gnt/rvalid handshake. Returns each fetched word with its PC to the decode stage as `instruction_IF` / `pc_IFR`, with a valid flag. Honours downstream `stall` and redirects from branch/jump resolution, discarding any in-flight response that was fetched on the wrong path.

## Interface
- `RESET_PC`, default 64'h0000_0000_8000_0000: first fetch address after reset.
- `NOP_INST`, default 32'h0000_0013: instruction word driven whenever the output is a bubble.
- `clk`  in  1: clock.
- `reset`  in  1: reset, asynchronous, active-low.
- `stall`  in  1: decode stage is holding; output registers must not advance.
- `redirect_valid`  in  1: taken jump/branch or flush; load `redirect_pc`.
- `redirect_pc`  in  64: new fetch address; bits [1:0] are forced to 0 on load.
- `imem_req`  out  1: fetch request.
- `imem_addr`  out  64: fetch address, equal to the current PC.
- `imem_gnt`  in  1: request accepted this cycle.
- `imem_rvalid`  in  1: read data valid, at least 1 cycle after `gnt`.
- `imem_rdata`  in  32: instruction word.
- `instruction_IF`  out  32: registered instruction to decode.
- `pc_IFR`  out  64: registered PC of `instruction_IF`.
- `valid_IF`  out  1: `instruction_IF` is a real fetched instruction.

## Operation
- FSM states: S_REQ, S_WAIT, S_HOLD. Internal registers: `pc`, `drop`, `hold_inst`, `hold_pc`.
- S_REQ:
  - `imem_req = !redirect_valid`, `imem_addr = pc`.
  - On `gnt` (and no redirect), go to S_WAIT.
  - On redirect, load the new `pc` and stay in S_REQ; no request is issued that cycle.
- S_WAIT:
  - `imem_req = 0`.
  - On `rvalid` with `drop` set or `redirect_valid` high: discard the word, clear `drop`, go to S_REQ.
  - On `rvalid` with `!stall`: output regs load {rdata, pc, valid=1}, `pc += 4`, go to S_REQ.
  - On `rvalid` with `stall`: capture into `hold_*`, `pc += 4`, go to S_HOLD.
  - On redirect without `rvalid`: load `pc`, set `drop`, stay in S_WAIT.
- S_HOLD:
  - When `!stall`, move `hold_*` into the output regs with valid=1 and go to S_REQ.
  - On redirect, discard `hold_*`, load `pc`, go to S_REQ.
- Output registers:
  - On `redirect_valid`, they load a bubble (NOP_INST, valid=0, `pc_IFR` unchanged) regardless of `stall`.
  - Otherwise, while `stall`, they hold their value.
  - Otherwise, if no instruction is delivered this cycle, they load a bubble.
- PC arithmetic: 64-bit modulo. FFFF_FFFF_FFFF_FFFC + 4 wraps to 0.
- `rvalid` in S_REQ or S_HOLD is a protocol violation and is ignored.
- At most one request is ever outstanding.

## Timing
- Reset values:
  - state=S_REQ, pc=RESET_PC, drop=0.
  - instruction_IF=NOP_INST, pc_IFR=0, valid_IF=0.
  - `imem_req` is asserted in the first cycle after reset release.
- Latency: `gnt` in cycle t, `rvalid` in cycle t+k (k≥1) → `valid_IF` high in cycle t+k+1.
  - Next `imem_req` is asserted in cycle t+k+1.
- Throughput with zero-wait memory (gnt same cycle, k=1): one instruction per 2 cycles.
- Redirect in cycle t: bubble on the output in t+1.
  - First request to the target is issued in t+1 (from S_REQ), or after the pending response is dropped (from S_WAIT).
- Redirect has priority over stall, `rvalid` and `gnt`.
- Reset mid-transaction returns to the reset values immediately. The memory side must tolerate the abandoned request.

## Structure
- `pipeline_pkg` holds:
  - `if_state_e` enum (S_REQ, S_WAIT, S_HOLD).
  - `RV_NOP` constant (32'h0000_0013).
  - `RESET_PC` default constant.
- Single module with no sub-modules. The one-entry hold buffer is inline: two registers plus the state.

## Test plan
- Reset release, memory with gnt same cycle, k=1, instructions at 0x8000_0000 and 0x8000_0004 → `valid_IF` pulses in cycles 3 and 5 with `pc_IFR` = 0x8000_0000 then 0x8000_0004.
- `stall` held for 4 cycles while `rvalid` arrives → word captured in hold; output unchanged during the stall; word appears one cycle after `stall` drops with the correct PC.
- Redirect to 0x8000_0100 while in S_WAIT, `rvalid` 3 cycles later → that response is dropped, next `imem_addr` = 0x8000_0100, and `valid_IF` never shows the stale word.
- Redirect in the same cycle as `rvalid` with `stall`=1 → output becomes bubble (NOP, valid 0); next request is to the target.
- `redirect_pc` = 0x8000_0203 → `imem_addr` = 0x8000_0200.
- PC wrap: redirect to 64'hFFFF_FFFF_FFFF_FFFC → next fetch address is 0.
- Async reset asserted mid-WAIT → immediate reset values; after release, first fetch is from RESET_PC.
